// File: rtl/jfpjc_frame_packager_pkg.sv
// ============================================================================
// Package : jfpjc_frame_packager_pkg
// Shared state encodings, JPEG marker bytes and COM tag helper for the packager.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jfpjc_frame_packager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_COMMENT = 3'd2,
    ST_BODY    = 3'd3,
    ST_EOI0    = 3'd4,
    ST_EOI1    = 3'd5
  } state_t;

  localparam logic [7:0]  MARK_FF  = 8'hFF;
  localparam logic [7:0]  MARK_EOI = 8'hD9;
  localparam logic [7:0]  MARK_COM = 8'hFE;
  localparam logic [15:0] COM_LEN  = 16'h0004;
  localparam logic [2:0]  COM_LAST = 3'd5;

  // FIFO entry {eof_marker, byte}; the marker carries no payload.
  localparam logic [8:0]  FIFO_MARKER = 9'h100;

  function automatic logic [7:0] com_byte(input logic [2:0] idx, input logic [15:0] cnt);
    case (idx)
      3'd0:    com_byte = MARK_FF;
      3'd1:    com_byte = MARK_COM;
      3'd2:    com_byte = COM_LEN[15:8];
      3'd3:    com_byte = COM_LEN[7:0];
      3'd4:    com_byte = cnt[15:8];
      default: com_byte = cnt[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/jfpjc_sync_fifo.sv
// ============================================================================
// Module  : jfpjc_sync_fifo
// First-word-fall-through FIFO with two ordered write ports per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jfpjc_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64
) (
  input  logic                     clock_i,
  input  logic                     nreset_i,
  input  logic                     wr0_en_i,
  input  logic [WIDTH-1:0]         wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [WIDTH-1:0]         wr1_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW-1:0]    w_wr_ptr1;

  assign w_wr_ptr1 = wr_ptr_q + AW'(1);

  // wr1 is only ever used together with wr0 and lands in the following slot.
  always_ff @(posedge clock_i) begin
    if (wr0_en_i) mem_q[wr_ptr_q]  <= wr0_data_i;
    if (wr1_en_i) mem_q[w_wr_ptr1] <= wr1_data_i;
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr1_en_i)      wr_ptr_q <= wr_ptr_q + AW'(2);
      else if (wr0_en_i) wr_ptr_q <= w_wr_ptr1;
      if (rd_en_i)       rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr0_en_i) + (AW+1)'(wr1_en_i) - (AW+1)'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/jfpjc_frame_packager.sv
// ============================================================================
// Module  : jfpjc_frame_packager
// Wraps jfpjc scan bytes into JPEG files: header EBR, optional COM tag, scan, FF D9.
// Optional feature macro: JFPJC_FRAME_COMMENT_EN (adds a COM segment with frame count).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jfpjc_frame_packager
  import jfpjc_frame_packager_pkg::*;
#(
  parameter int HDR_LEN     = 328,
  parameter int FIFO_DEPTH  = 64,
  parameter int FRAME_LEN_W = 17
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        vsync,
  output logic [$clog2(HDR_LEN)-1:0]  hdr_addr,
  input  logic [7:0]                  hdr_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic                        out_sof,
  output logic                        out_eof,
  output logic [FRAME_LEN_W-1:0]      frame_len,
  output logic [15:0]                 frame_count,
  output logic                        overflow
);

  localparam int AW = $clog2(HDR_LEN);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0]            HDR_END  = (AW+1)'(HDR_LEN);
  localparam logic [AW-1:0]          HDR_LAST = AW'(HDR_LEN - 1);
  localparam logic [FRAME_LEN_W-1:0] LEN_MAX  = '1;

  state_t                  state_q;
  logic                    vsync_prev_q, marker_pending_q, marker_pending_d;
  logic                    overflow_q, overflow_d;
  logic [AW:0]             iss_q;
  logic [AW-1:0]           hcnt_q;
  logic                    rd_v_q, pf_v_q;
  logic [7:0]              pf_q;
  logic                    out_valid_q, out_sof_q, out_eof_q;
  logic [7:0]              out_data_q;
  logic [FRAME_LEN_W-1:0]  byte_cnt_q, frame_len_q;
  logic [15:0]             frame_count_q;
`ifdef JFPJC_FRAME_COMMENT_EN
  logic [2:0]              com_idx_q;
`endif

  logic                    w_fifo_wr0, w_fifo_wr1, w_fifo_empty, w_fifo_full;
  logic [8:0]              w_fifo_din0, w_fifo_din1, w_fifo_dout;
  logic [CW-1:0]           w_fifo_count;
  logic [CW:0]             w_free;
  logic                    w_pop, w_room1, w_room2, w_edge, w_is_mark;
  logic                    w_a_v, w_b_v, w_push_a, w_push_b, w_byte_ok, w_mark_ok;
  logic [8:0]              w_a_d, w_b_d;
  logic                    w_ld_ok, w_hdr_av, w_hdr_take, w_issue;
  logic [7:0]              w_hdr_byte;

  jfpjc_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i    (clock),
    .nreset_i   (nreset),
    .wr0_en_i   (w_fifo_wr0),
    .wr0_data_i (w_fifo_din0),
    .wr1_en_i   (w_fifo_wr1),
    .wr1_data_i (w_fifo_din1),
    .rd_en_i    (w_pop),
    .rd_data_o  (w_fifo_dout),
    .empty_o    (w_fifo_empty),
    .full_o     (w_fifo_full),
    .count_o    (w_fifo_count)
  );

  assign w_ld_ok    = !out_valid_q || out_ready;
  assign w_is_mark  = w_fifo_dout[8];
  assign w_pop      = (state_q == ST_BODY) && !w_fifo_empty && (w_is_mark || w_ld_ok);
  assign w_free     = (CW+1)'(FIFO_DEPTH) - (CW+1)'(w_fifo_count) + (CW+1)'(w_pop);
  assign w_room1    = !w_fifo_full || w_pop;
  assign w_room2    = (w_free >= (CW+1)'(2));

  // Header prefetch: prefetch and in-flight read are never both occupied, so a
  // new read is issued only when this cycle leaves both empty.
  assign w_hdr_av   = pf_v_q || rd_v_q;
  assign w_hdr_byte = pf_v_q ? pf_q : hdr_data;
  assign w_hdr_take = (state_q == ST_HEADER) && w_hdr_av && w_ld_ok;
  assign w_issue    = (state_q == ST_HEADER) && (iss_q < HDR_END) && (!w_hdr_av || w_hdr_take);

  // Two ordered slots per cycle: a pending marker precedes the new byte, while a
  // byte coincident with the vsync edge precedes that edge's marker.
  always_comb begin
    w_edge = vsync && !vsync_prev_q;
    if (marker_pending_q) begin
      w_a_v = 1'b1;     w_a_d = FIFO_MARKER;
      w_b_v = in_valid; w_b_d = {1'b0, in_data};
    end else begin
      w_a_v = in_valid; w_a_d = {1'b0, in_data};
      w_b_v = w_edge;   w_b_d = FIFO_MARKER;
    end
    w_push_a         = w_a_v && w_room1;
    w_push_b         = w_b_v && (w_a_v ? w_room2 : w_room1);
    w_fifo_wr0       = w_push_a || w_push_b;
    w_fifo_din0      = w_a_v ? w_a_d : w_b_d;
    w_fifo_wr1       = w_push_a && w_push_b;
    w_fifo_din1      = w_b_d;
    w_byte_ok        = marker_pending_q ? w_push_b : w_push_a;
    w_mark_ok        = marker_pending_q ? w_push_a : w_push_b;
    marker_pending_d = (marker_pending_q || w_edge) && !w_mark_ok;
    overflow_d       = overflow_q || (in_valid && !w_byte_ok);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      vsync_prev_q     <= 1'b0;
      marker_pending_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      vsync_prev_q     <= vsync;
      marker_pending_q <= marker_pending_d;
      overflow_q       <= overflow_d;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      iss_q         <= '0;
      hcnt_q        <= '0;
      rd_v_q        <= 1'b0;
      pf_v_q        <= 1'b0;
      pf_q          <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_data_q    <= '0;
      byte_cnt_q    <= '0;
      frame_len_q   <= '0;
      frame_count_q <= '0;
`ifdef JFPJC_FRAME_COMMENT_EN
      com_idx_q     <= '0;
`endif
    end else begin
      rd_v_q <= w_issue;
      if (w_issue) iss_q <= iss_q + 1'b1;
      if (w_hdr_take && pf_v_q) begin
        pf_v_q <= rd_v_q;
        pf_q   <= hdr_data;
      end else if (!w_hdr_take && rd_v_q) begin
        pf_v_q <= 1'b1;
        pf_q   <= hdr_data;
      end

      if (w_ld_ok) begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
      if (out_valid_q && out_ready && byte_cnt_q != LEN_MAX) byte_cnt_q <= byte_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            state_q    <= ST_HEADER;
            iss_q      <= '0;
            hcnt_q     <= '0;
            byte_cnt_q <= '0;
          end
        end
        ST_HEADER: begin
          if (w_hdr_take) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_hdr_byte;
            out_sof_q   <= (hcnt_q == '0);
            hcnt_q      <= hcnt_q + 1'b1;
            if (hcnt_q == HDR_LAST) begin
`ifdef JFPJC_FRAME_COMMENT_EN
              state_q   <= ST_COMMENT;
              com_idx_q <= '0;
`else
              state_q   <= ST_BODY;
`endif
            end
          end
        end
`ifdef JFPJC_FRAME_COMMENT_EN
        ST_COMMENT: begin
          if (w_ld_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= com_byte(com_idx_q, frame_count_q);
            com_idx_q   <= com_idx_q + 1'b1;
            if (com_idx_q == COM_LAST) state_q <= ST_BODY;
          end
        end
`endif
        ST_BODY: begin
          if (w_pop) begin
            if (w_is_mark) begin
              state_q <= ST_EOI0;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= w_fifo_dout[7:0];
            end
          end
        end
        ST_EOI0: begin
          if (w_ld_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= MARK_FF;
            state_q     <= ST_EOI1;
          end
        end
        ST_EOI1: begin
          // Stay here until D9 is taken so the next frame cannot clear the counter early.
          if (out_valid_q && out_eof_q && out_ready) begin
            state_q       <= ST_IDLE;
            frame_len_q   <= (byte_cnt_q == LEN_MAX) ? LEN_MAX : byte_cnt_q + 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end else if (!out_eof_q && w_ld_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= MARK_EOI;
            out_eof_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hdr_addr    = iss_q[AW-1:0];
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign frame_len   = frame_len_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire
